// File: rtl/braille_seq_pkg.sv
// Shared types and constants for the braille entry sequencer and its debounce block.
package braille_seq_pkg;

  localparam int CELL_W = 6;

  typedef logic [CELL_W-1:0] cell_t;

  typedef enum logic [1:0] {IDLE, ARM, COMMIT, RELEASE} deb_state_e;

endpackage

// File: rtl/braille_debounce.sv
// Two-flop synchroniser plus press/release debounce FSM; emits one pulse per accepted press.
module braille_debounce
  import braille_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             raw_s;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign raw_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt holds the number of stable cycles already seen, so the
  // DEBOUNCE_CYCLES-th stable cycle is the one with cnt == CNT_LAST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (raw_s) begin
          state_d = ARM;
          cnt_d   = CNT_W'(1);
        end
      end
      ARM: begin
        if (!raw_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = COMMIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      COMMIT: begin
        pulse   = 1'b1;
        state_d = RELEASE;
        cnt_d   = '0;
      end
      RELEASE: begin
        if (raw_s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/braille_entry_sequencer.sv
// Captures debounced braille cells into a shift buffer and scans it onto one shared decoder path.
// Optional backspace button enabled by defining BRAILLE_SEQ_BKSP_EN.
module braille_entry_sequencer
  import braille_seq_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_CYCLES     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CELL_W-1:0]             dots,
  input  logic                          enter,
  input  logic                          clear,
`ifdef BRAILLE_SEQ_BKSP_EN
  input  logic                          bksp,
`endif
  output logic [CELL_W-1:0]             cell_out,
  output logic                          blank,
  output logic [DIGITS-1:0]             digit_sel,
  output logic                          commit,
  output logic [$clog2(DIGITS+1)-1:0]   count,
  output logic                          full
);

  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int IDX_W  = $clog2(DIGITS);
  localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DIGITS);

  cell_t                    dots_s1_q, dots_s_q;
  cell_t [DIGITS-1:0]       cells_q, cells_d;
  logic  [DIGITS-1:0]       valid_q, valid_d;
  logic  [CNT_W-1:0]        count_q, count_d;
  logic  [SCAN_W-1:0]       scan_cnt_q, scan_cnt_d;
  logic  [IDX_W-1:0]        scan_idx_q, scan_idx_d;
  cell_t                    cell_out_q;
  logic                     blank_q;
  logic  [DIGITS-1:0]       digit_sel_q;

  braille_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (enter),
    .pulse (commit)
  );

`ifdef BRAILLE_SEQ_BKSP_EN
  logic bksp_pulse;

  braille_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bksp_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bksp),
    .pulse (bksp_pulse)
  );
`endif

  // Priority: clear, then enter commit, then backspace.
  always_comb begin
    cells_d = cells_q;
    valid_d = valid_q;
    count_d = count_q;
    if (clear) begin
      cells_d = '0;
      valid_d = '0;
      count_d = '0;
    end else if (commit) begin
      cells_d = {cells_q[DIGITS-2:0], dots_s_q};
      valid_d = {valid_q[DIGITS-2:0], 1'b1};
      if (count_q != CNT_FULL) count_d = count_q + CNT_W'(1);
    end
`ifdef BRAILLE_SEQ_BKSP_EN
    else if (bksp_pulse && (count_q != '0)) begin
      cells_d = {cell_t'(0), cells_q[DIGITS-1:1]};
      valid_d = {1'b0, valid_q[DIGITS-1:1]};
      count_d = count_q - CNT_W'(1);
    end
`endif
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
    end
  end

  // Display registers load from next-state values so a buffer update and a
  // scan step both land on the outputs at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dots_s1_q   <= '0;
      dots_s_q    <= '0;
      cells_q     <= '0;
      valid_q     <= '0;
      count_q     <= '0;
      scan_cnt_q  <= '0;
      scan_idx_q  <= '0;
      cell_out_q  <= '0;
      blank_q     <= 1'b1;
      digit_sel_q <= DIGITS'(1);
    end else begin
      dots_s1_q   <= dots;
      dots_s_q    <= dots_s1_q;
      cells_q     <= cells_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
      scan_cnt_q  <= scan_cnt_d;
      scan_idx_q  <= scan_idx_d;
      cell_out_q  <= valid_d[scan_idx_d] ? cells_d[scan_idx_d] : '0;
      blank_q     <= ~valid_d[scan_idx_d];
      digit_sel_q <= DIGITS'(1) << scan_idx_d;
    end
  end

  assign cell_out  = cell_out_q;
  assign blank     = blank_q;
  assign digit_sel = digit_sel_q;
  assign count     = count_q;
  assign full      = (count_q == CNT_FULL);

endmodule
